// File: rtl/fir_filter_mac_param.sv
// Time-multiplexed FIR filter: one signed multiplier walks NTAPS loadable taps per sample,
// then rounds and saturates the full-precision sum back to DATA_W.
module fir_filter_mac_param #(
    parameter int DATA_W = 24,
    parameter int COEF_W = 24,
    parameter int NTAPS  = 25,
    parameter int ACC_W  = 56,
    parameter int SHIFT  = 23,
    parameter int AW     = $clog2(NTAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic signed [ACC_W-1:0]  acc_out
);

    localparam int PW = DATA_W + COEF_W;
    localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] HALF =
        (SHIFT > 0) ? ((ACC_W+1)'(1) << HS) : '0;
    localparam logic signed [ACC_W:0] SATMAX =
        {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SATMIN =
        {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state, next_state;

    logic signed [DATA_W-1:0] x [NTAPS];
    logic signed [COEF_W-1:0] c [NTAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            k;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W:0]    acc_ext;
    logic signed [ACC_W:0]    rounded;
    logic signed [DATA_W-1:0] sat_data;
    logic                     last_tap;
    logic                     coef_ok;

    assign last_tap = (k == AW'(NTAPS-1));
    assign coef_ok  = coef_we && (state == IDLE) &&
                      ({1'b0, coef_addr} < (AW+1)'(NTAPS));
    assign prod     = c[k] * x[k];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = MAC;
            end
            MAC:     if (last_tap) next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Delay line shifts on accept; the accumulator is cleared there so MAC starts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) x[i] <= '0;
            acc <= '0;
            k   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x[0] <= in_data;
                    for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
                    acc <= '0;
                    k   <= '0;
                end
                MAC: begin
                    acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
                    k   <= last_tap ? '0 : k + AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) c[i] <= '0;
        end else if (coef_ok) begin
            c[coef_addr] <= coef_data;
        end
    end

    // One extra bit of headroom keeps the rounding offset from wrapping a large positive sum.
    always_comb begin
        acc_ext = {acc[ACC_W-1], acc};
        rounded = (acc_ext + HALF) >>> SHIFT;
        if (rounded > SATMAX)      sat_data = SATMAX[DATA_W-1:0];
        else if (rounded < SATMIN) sat_data = SATMIN[DATA_W-1:0];
        else                       sat_data = rounded[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            acc_out   <= '0;
        end else begin
            out_valid <= (state == OUT);
            if (state == OUT) begin
                acc_out  <= acc;
                out_data <= sat_data;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_mac_param.sv
// Scoreboard bench for fir_filter_mac_param: a tap-sum reference model predicts every output,
// a separate monitor checks each out_valid pulse against the queued prediction.
module tb_fir_filter_mac_param;

    localparam int DATA_W = 24;
    localparam int COEF_W = 24;
    localparam int NTAPS  = 25;
    localparam int ACC_W  = 56;
    localparam int SHIFT  = 23;
    localparam int AW     = $clog2(NTAPS);
    localparam int HS     = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam longint MAXV = (longint'(1) <<< (DATA_W-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DATA_W-1));

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic                     coef_we = 1'b0;
    logic [AW-1:0]            coef_addr = '0;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic signed [ACC_W-1:0]  acc_out;

    fir_filter_mac_param #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS),
        .ACC_W(ACC_W), .SHIFT(SHIFT), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_data(out_data), .acc_out(acc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [ACC_W-1:0]  acc;
        logic signed [DATA_W-1:0] data;
        int                       edgeNo;
    } exp_t;

    exp_t   sbq[$];
    int     compared = 0;
    int     mismatched = 0;
    int     edgeCount = 0;
    longint mx[NTAPS];
    longint mc[NTAPS];
    int     busy = 0;
    bit     lastAccept = 0;

    always @(posedge clk) edgeCount++;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, $signed(actual), $signed(expected), $time);
        end
    endtask

    // Reference: direct convolution of the current delay line with the current coefficients.
    function automatic exp_t expectedFor(input int acceptEdge);
        longint sum = 0;
        longint r;
        logic signed [ACC_W-1:0] wrapped;
        exp_t e;
        for (int i = 0; i < NTAPS; i++) sum += mc[i] * mx[i];
        wrapped = sum[ACC_W-1:0];
        sum = longint'(wrapped);
        r = (SHIFT == 0) ? sum : ((sum + (longint'(1) <<< HS)) >>> SHIFT);
        if (r > MAXV)      r = MAXV;
        else if (r < MINV) r = MINV;
        e.acc    = wrapped;
        e.data   = r[DATA_W-1:0];
        e.edgeNo = acceptEdge + NTAPS + 1;
        return e;
    endfunction

    task automatic modelTick();
        lastAccept = 0;
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                mx[i] = 0;
                mc[i] = 0;
            end
            busy = 0;
            sbq.delete();
        end else if (busy == 0) begin
            if (coef_we && int'(coef_addr) < NTAPS) mc[coef_addr] = longint'(coef_data);
            if (in_valid) begin
                for (int i = NTAPS-1; i > 0; i--) mx[i] = mx[i-1];
                mx[0] = longint'(in_data);
                sbq.push_back(expectedFor(edgeCount));
                busy = NTAPS + 1;
                lastAccept = 1;
            end
        end else begin
            busy--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        modelTick();
        checkOutput("in_ready", 64'(in_ready), 64'(busy == 0));
    endtask

    // Leaves in_valid high so back-to-back calls present a continuously valid source.
    task automatic applyStimulus(input logic signed [DATA_W-1:0] d, input logic we,
                                 input logic [AW-1:0] a, input logic signed [COEF_W-1:0] cd);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        coef_we   = we;
        coef_addr = a;
        coef_data = cd;
        do begin
            tick();
            n++;
        end while (!lastAccept && n < 4*NTAPS);
        checkOutput("accept", 64'(lastAccept), 64'(1));
        coef_we = 1'b0;
    endtask

    task automatic writeCoef(input logic [AW-1:0] a, input logic signed [COEF_W-1:0] cd);
        in_valid  = 1'b0;
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = cd;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((sbq.size() != 0 || busy != 0) && n < 4*NTAPS) begin
            tick();
            n++;
        end
        checkOutput("drain", 64'(sbq.size()), 64'(0));
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_out_valid: got pulse, expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("acc_out", 64'(acc_out), 64'(e.acc));
                checkOutput("out_data", 64'(out_data), 64'(e.data));
                checkOutput("latency_edge", 64'(edgeCount), 64'(e.edgeNo));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_out_data", 64'(out_data), 64'(0));
        checkOutput("reset_acc_out", 64'(acc_out), 64'(0));

        $display("[TB] impulse response");
        for (int i = 0; i < NTAPS; i++) writeCoef(AW'(i), COEF_W'((i + 1) << 18));
        applyStimulus(DATA_W'(1), 1'b0, '0, '0);
        for (int i = 0; i < 29; i++) applyStimulus('0, 1'b0, '0, '0);
        drain();

        $display("[TB] back-to-back handshake");
        for (int i = 0; i < 3; i++) applyStimulus(DATA_W'(1000 * (i + 1)), 1'b0, '0, '0);
        drain();

        $display("[TB] saturation");
        for (int i = 0; i < NTAPS; i++) writeCoef(AW'(i), 24'sh400000);
        for (int i = 0; i < NTAPS; i++) applyStimulus(24'sh7FFFFF, 1'b0, '0, '0);
        for (int i = 0; i < NTAPS; i++) applyStimulus(-24'sh800000, 1'b0, '0, '0);
        drain();

        $display("[TB] rounding");
        writeCoef('0, 24'sh400000);
        for (int i = 1; i < NTAPS; i++) writeCoef(AW'(i), '0);
        applyStimulus(DATA_W'(3), 1'b0, '0, '0);
        applyStimulus(-DATA_W'(3), 1'b0, '0, '0);
        applyStimulus(DATA_W'(2), 1'b0, '0, '0);
        drain();

        $display("[TB] reset during MAC");
        applyStimulus(DATA_W'(12345), 1'b0, '0, '0);
        idleCycles(9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("midreset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("midreset_out_data", 64'(out_data), 64'(0));
        checkOutput("midreset_acc_out", 64'(acc_out), 64'(0));
        applyStimulus(DATA_W'(1), 1'b0, '0, '0);
        applyStimulus('0, 1'b0, '0, '0);
        drain();

        $display("[TB] ignored coefficient writes");
        writeCoef('0, 24'sh123456);
        writeCoef(AW'(NTAPS + 2), 24'sh7ABCDE);
        applyStimulus('0, 1'b0, '0, '0);
        idleCycles(3);
        writeCoef('0, COEF_W'(5));
        drain();
        applyStimulus(DATA_W'(1), 1'b0, '0, '0);
        drain();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                writeCoef(AW'($urandom_range(0, (1 << AW) - 1)), COEF_W'($urandom));
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 4));
            applyStimulus(DATA_W'($urandom), 1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, (1 << AW) - 1)), COEF_W'($urandom));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
